rvfi_trace_packer: RTL and testbench
====================================

// Module: rvfi_trace_packer
// PURPOSE
//  Producer side of the RVFI trace: assembles one retirement packet per instruction from the
//  multi-cycle core's decode, register-read, memory-handshake, writeback and retire events, and
//  drives the RVFI bus consumed by the formal insn/consistency checkers. Sits inside the core
//  wrapper, in parallel with execution; it never stalls or back-pressures the core. NRET=1.
// PARAMETERS
//  XLEN        32  data/address width; RVFI mem masks are XLEN/8 bits
//  ORDER_W     64  width of rvfi_order retirement counter
// PORTS
//  clock          in   1        clock
//  reset          in   1        reset, synchronous, active-low
//  dec_valid      in   1        1-cycle pulse: instruction decoded, packet opens
//  dec_pc         in   XLEN     pc of decoded insn
//  dec_insn       in   32       instruction word
//  dec_rs1_addr   in   5        rs1 index (0 if unused)
//  dec_rs2_addr   in   5        rs2 index (0 if unused)
//  rf_rs1_rdata   in   XLEN     rs1 value, valid with dec_valid
//  rf_rs2_rdata   in   XLEN     rs2 value, valid with dec_valid
//  mem_valid      in   1        core data-bus request
//  mem_ready      in   1        bus accept; handshake = mem_valid & mem_ready
//  mem_instr      in   1        1 = fetch transaction (ignored by packer)
//  mem_addr       in   XLEN     data address
//  mem_rmask      in   XLEN/8   load byte mask (0 for stores)
//  mem_wstrb      in   XLEN/8   store byte strobes (0 for loads)
//  mem_wdata      in   XLEN     store data
//  mem_rdata      in   XLEN     load data, valid on handshake
//  wb_valid       in   1        register-file write pulse
//  wb_rd_addr     in   5        destination index
//  wb_rd_wdata    in   XLEN     destination value
//  ret_valid      in   1        1-cycle pulse: instruction retires, packet closes
//  ret_pc_next    in   XLEN     next pc
//  ret_trap       in   1        retirement is a trap
//  rvfi_valid     out  1        packet valid, exactly 1 cycle per retirement
//  rvfi_order     out  ORDER_W  retirement index of current packet
//  rvfi_insn/rvfi_trap/rvfi_pc_rdata/rvfi_pc_wdata  out  32/1/XLEN/XLEN  packet fields
//  rvfi_rs1_addr/rvfi_rs2_addr/rvfi_rs1_rdata/rvfi_rs2_rdata  out  5/5/XLEN/XLEN  source fields
//  rvfi_rd_addr/rvfi_rd_wdata  out  5/XLEN  destination fields
//  rvfi_mem_addr/rvfi_mem_rmask/rvfi_mem_wmask/rvfi_mem_rdata/rvfi_mem_wdata  out  XLEN/XLEN/8 x2/XLEN x2
//  proto_err      out  1        sticky: core event-sequence violation
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE, all outputs and shadow regs 0, rvfi_order 0, proto_err 0.
//  FSM: IDLE --dec_valid--> EXEC --ret_valid--> EMIT; EMIT lasts 1 cycle -> IDLE, or -> EXEC if
//   dec_valid in the EMIT cycle (back-to-back insns, no bubble required).
//  dec_valid (IDLE/EMIT): capture pc, insn, rs addrs; rs*_rdata forced 0 when rs addr==0;
//   clear rd/mem shadows to 0.
//  EXEC: first non-fetch handshake captures addr, rmask, wmask=wstrb, rdata, wdata. A second
//   non-fetch handshake sets proto_err, fields unchanged. Fetch handshakes ignored in all states.
//  EXEC: wb_valid captures rd_addr/rd_wdata (last write wins); rd_addr==0 -> rd_wdata 0.
//  Same-cycle events: wb and/or mem handshake with ret_valid are included in that packet.
//  ret_valid in EXEC: pc_wdata<=ret_pc_next, trap<=ret_trap; next cycle rvfi_valid=1 with
//   all fields (latency 1 cycle from ret_valid). If trap: rd_addr, rd_wdata, mem_wmask forced 0.
//  rvfi_order: value in packet = count of prior emissions; increments after EMIT, wraps 2^ORDER_W-1->0.
//  rvfi_valid=0 outside EMIT; other rvfi_* hold last packet values.
//  Errors (set proto_err, never clears until reset): dec_valid in EXEC -> discard open packet,
//   restart with new insn, order unchanged; ret_valid in IDLE -> ignored, no packet.
//  Reset mid-packet: packet discarded, no rvfi_valid, order back to 0.
// TESTING
//  ADD x3,x1,x2 (x1=5,x2=7): dec, wb rd=3 val 12, ret next=pc+4 -> 1 packet, rd_wdata=12, order=0.
//  LW x5,0(x6) addr 0x100 rdata 0xDEADBEEF, wb+ret same cycle -> rmask=0xF, rd_wdata=0xDEADBEEF.
//  SB with trap, wstrb=0x1 -> rvfi_trap=1, rd_addr=0, rd_wdata=0, mem_wmask=0.
//  Back-to-back: dec_valid in EMIT cycle -> consecutive packets order 0,1, no dropped insn.
//  dec_valid in EXEC; ret_valid in IDLE -> proto_err=1, no spurious packet, order unchanged.
//  Preload order=2^64-1 (force), one retire -> packet order=all-ones, next packet order=0.

Source files
------------

// File: rtl/rvfi_trace_packer.sv
// RVFI retirement packet builder (NRET=1): collects decode, memory, writeback and retire
// events of one instruction into shadow registers and presents them as a one-cycle packet.
module rvfi_trace_packer #(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dec_valid,
    input  logic [XLEN-1:0]      dec_pc,
    input  logic [31:0]          dec_insn,
    input  logic [4:0]           dec_rs1_addr,
    input  logic [4:0]           dec_rs2_addr,
    input  logic [XLEN-1:0]      rf_rs1_rdata,
    input  logic [XLEN-1:0]      rf_rs2_rdata,
    input  logic                 mem_valid,
    input  logic                 mem_ready,
    input  logic                 mem_instr,
    input  logic [XLEN-1:0]      mem_addr,
    input  logic [XLEN/8-1:0]    mem_rmask,
    input  logic [XLEN/8-1:0]    mem_wstrb,
    input  logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd_addr,
    input  logic [XLEN-1:0]      wb_rd_wdata,
    input  logic                 ret_valid,
    input  logic [XLEN-1:0]      ret_pc_next,
    input  logic                 ret_trap,
    output logic                 rvfi_valid,
    output logic [ORDER_W-1:0]   rvfi_order,
    output logic [31:0]          rvfi_insn,
    output logic                 rvfi_trap,
    output logic [XLEN-1:0]      rvfi_pc_rdata,
    output logic [XLEN-1:0]      rvfi_pc_wdata,
    output logic [4:0]           rvfi_rs1_addr,
    output logic [4:0]           rvfi_rs2_addr,
    output logic [XLEN-1:0]      rvfi_rs1_rdata,
    output logic [XLEN-1:0]      rvfi_rs2_rdata,
    output logic [4:0]           rvfi_rd_addr,
    output logic [XLEN-1:0]      rvfi_rd_wdata,
    output logic [XLEN-1:0]      rvfi_mem_addr,
    output logic [XLEN/8-1:0]    rvfi_mem_rmask,
    output logic [XLEN/8-1:0]    rvfi_mem_wmask,
    output logic [XLEN-1:0]      rvfi_mem_rdata,
    output logic [XLEN-1:0]      rvfi_mem_wdata,
    output logic                 proto_err
);

    typedef enum logic [1:0] {IDLE, EXEC, EMIT} state_t;

    state_t              state_reg;
    logic [ORDER_W-1:0]  order_reg;
    logic [XLEN-1:0]     pc_reg;
    logic [31:0]         insn_reg;
    logic [4:0]          rs1_addr_reg, rs2_addr_reg;
    logic [XLEN-1:0]     rs1_rdata_reg, rs2_rdata_reg;
    logic [4:0]          rd_addr_reg, rd_addr_next;
    logic [XLEN-1:0]     rd_wdata_reg, rd_wdata_next;
    logic                mem_seen_reg, mem_seen_next;
    logic [XLEN-1:0]     mem_addr_reg, mem_addr_next;
    logic [XLEN/8-1:0]   mem_rmask_reg, mem_rmask_next;
    logic [XLEN/8-1:0]   mem_wmask_reg, mem_wmask_next;
    logic [XLEN-1:0]     mem_rdata_reg, mem_rdata_next;
    logic [XLEN-1:0]     mem_wdata_reg, mem_wdata_next;

    logic mem_fire;
    assign mem_fire   = mem_valid & mem_ready & ~mem_instr;
    assign rvfi_order = order_reg;

    // Next-state shadows fold in this cycle's events so a retire can include them.
    always_comb begin
        rd_addr_next   = rd_addr_reg;
        rd_wdata_next  = rd_wdata_reg;
        mem_seen_next  = mem_seen_reg;
        mem_addr_next  = mem_addr_reg;
        mem_rmask_next = mem_rmask_reg;
        mem_wmask_next = mem_wmask_reg;
        mem_rdata_next = mem_rdata_reg;
        mem_wdata_next = mem_wdata_reg;
        if (state_reg == EXEC) begin
            if (wb_valid) begin
                rd_addr_next  = wb_rd_addr;
                rd_wdata_next = (wb_rd_addr == 5'd0) ? '0 : wb_rd_wdata;
            end
            if (mem_fire && !mem_seen_reg) begin
                mem_seen_next  = 1'b1;
                mem_addr_next  = mem_addr;
                mem_rmask_next = mem_rmask;
                mem_wmask_next = mem_wstrb;
                mem_rdata_next = mem_rdata;
                mem_wdata_next = mem_wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= IDLE;
            order_reg      <= '0;
            pc_reg         <= '0;
            insn_reg       <= '0;
            rs1_addr_reg   <= '0;
            rs2_addr_reg   <= '0;
            rs1_rdata_reg  <= '0;
            rs2_rdata_reg  <= '0;
            rd_addr_reg    <= '0;
            rd_wdata_reg   <= '0;
            mem_seen_reg   <= 1'b0;
            mem_addr_reg   <= '0;
            mem_rmask_reg  <= '0;
            mem_wmask_reg  <= '0;
            mem_rdata_reg  <= '0;
            mem_wdata_reg  <= '0;
            rvfi_valid     <= 1'b0;
            rvfi_insn      <= '0;
            rvfi_trap      <= 1'b0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
            proto_err      <= 1'b0;
        end else begin
            rvfi_valid <= 1'b0;
            if (state_reg == EMIT)
                order_reg <= order_reg + 1'b1;
            if (dec_valid) begin
                // A decode while a packet is still open abandons that packet.
                if (state_reg == EXEC)
                    proto_err <= 1'b1;
                state_reg     <= EXEC;
                pc_reg        <= dec_pc;
                insn_reg      <= dec_insn;
                rs1_addr_reg  <= dec_rs1_addr;
                rs2_addr_reg  <= dec_rs2_addr;
                rs1_rdata_reg <= (dec_rs1_addr == 5'd0) ? '0 : rf_rs1_rdata;
                rs2_rdata_reg <= (dec_rs2_addr == 5'd0) ? '0 : rf_rs2_rdata;
                rd_addr_reg   <= '0;
                rd_wdata_reg  <= '0;
                mem_seen_reg  <= 1'b0;
                mem_addr_reg  <= '0;
                mem_rmask_reg <= '0;
                mem_wmask_reg <= '0;
                mem_rdata_reg <= '0;
                mem_wdata_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (ret_valid)
                            proto_err <= 1'b1;
                    end
                    EXEC: begin
                        if (mem_fire && mem_seen_reg)
                            proto_err <= 1'b1;
                        rd_addr_reg   <= rd_addr_next;
                        rd_wdata_reg  <= rd_wdata_next;
                        mem_seen_reg  <= mem_seen_next;
                        mem_addr_reg  <= mem_addr_next;
                        mem_rmask_reg <= mem_rmask_next;
                        mem_wmask_reg <= mem_wmask_next;
                        mem_rdata_reg <= mem_rdata_next;
                        mem_wdata_reg <= mem_wdata_next;
                        if (ret_valid) begin
                            state_reg      <= EMIT;
                            rvfi_valid     <= 1'b1;
                            rvfi_insn      <= insn_reg;
                            rvfi_trap      <= ret_trap;
                            rvfi_pc_rdata  <= pc_reg;
                            rvfi_pc_wdata  <= ret_pc_next;
                            rvfi_rs1_addr  <= rs1_addr_reg;
                            rvfi_rs2_addr  <= rs2_addr_reg;
                            rvfi_rs1_rdata <= rs1_rdata_reg;
                            rvfi_rs2_rdata <= rs2_rdata_reg;
                            rvfi_rd_addr   <= ret_trap ? 5'd0 : rd_addr_next;
                            rvfi_rd_wdata  <= ret_trap ? '0 : rd_wdata_next;
                            rvfi_mem_addr  <= mem_addr_next;
                            rvfi_mem_rmask <= mem_rmask_next;
                            rvfi_mem_wmask <= ret_trap ? '0 : mem_wmask_next;
                            rvfi_mem_rdata <= mem_rdata_next;
                            rvfi_mem_wdata <= mem_wdata_next;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rvfi_trace_packer.sv
// Directed bench for rvfi_trace_packer: ALU, load, trapping store, back-to-back,
// protocol errors, reset mid-packet and order wrap-around.
module tb_rvfi_trace_packer;
    logic        clock = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [31:0] dec_pc, dec_insn;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr;
    logic [31:0] rf_rs1_rdata, rf_rs2_rdata;
    logic        mem_valid, mem_ready, mem_instr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_rmask, mem_wstrb;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_wdata;
    logic        ret_valid, ret_trap;
    logic [31:0] ret_pc_next;
    logic        rvfi_valid, rvfi_trap, proto_err;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    rvfi_trace_packer #(.XLEN(32), .ORDER_W(64)) dut (
        .clock(clock), .reset(reset),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_insn(dec_insn),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .rf_rs1_rdata(rf_rs1_rdata), .rf_rs2_rdata(rf_rs2_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
        .ret_valid(ret_valid), .ret_pc_next(ret_pc_next), .ret_trap(ret_trap),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .proto_err(proto_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; mem_valid = 0; mem_ready = 0; mem_instr = 0;
        mem_rmask = 0; mem_wstrb = 0; wb_valid = 0; ret_valid = 0; ret_trap = 0;
    endtask

    task automatic decode(input logic [31:0] pc, input logic [31:0] insn,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2);
        dec_valid = 1; dec_pc = pc; dec_insn = insn;
        dec_rs1_addr = rs1; dec_rs2_addr = rs2; rf_rs1_rdata = d1; rf_rs2_rdata = d2;
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        dec_pc = 0; dec_insn = 0; dec_rs1_addr = 0; dec_rs2_addr = 0;
        rf_rs1_rdata = 0; rf_rs2_rdata = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
        wb_rd_addr = 0; wb_rd_wdata = 0; ret_pc_next = 0;
        step(); step();
        reset = 1;
        check("reset_valid", rvfi_valid, 0);
        check("reset_order", rvfi_order, 0);
        check("reset_err", proto_err, 0);
        check("reset_insn", rvfi_insn, 0);

        // ADD x3,x1,x2 with an ignored fetch handshake
        decode(32'h1000, 32'h002081B3, 5'd1, 5'd2, 32'd5, 32'd7);
        step(); idle_inputs();
        wb_valid = 1; wb_rd_addr = 3; wb_rd_wdata = 32'd12;
        mem_valid = 1; mem_ready = 1; mem_instr = 1; mem_addr = 32'h1004; mem_rmask = 4'hF;
        step(); idle_inputs();
        ret_valid = 1; ret_pc_next = 32'h1004;
        step(); idle_inputs();
        check("add_valid", rvfi_valid, 1);
        check("add_order", rvfi_order, 0);
        check("add_insn", rvfi_insn, 32'h002081B3);
        check("add_pc_rdata", rvfi_pc_rdata, 32'h1000);
        check("add_pc_wdata", rvfi_pc_wdata, 32'h1004);
        check("add_rs1_rdata", rvfi_rs1_rdata, 5);
        check("add_rs2_rdata", rvfi_rs2_rdata, 7);
        check("add_rd_addr", rvfi_rd_addr, 3);
        check("add_rd_wdata", rvfi_rd_wdata, 12);
        check("add_mem_addr", rvfi_mem_addr, 0);
        check("add_mem_rmask", rvfi_mem_rmask, 0);
        step();
        check("add_valid_drop", rvfi_valid, 0);
        check("add_hold_rd", rvfi_rd_wdata, 12);

        // LW x5,0(x6): memory, writeback and retire all in the same cycle
        decode(32'h1004, 32'h00032283, 5'd6, 5'd0, 32'h100, 32'h55);
        step(); idle_inputs();
        mem_valid = 1; mem_ready = 1; mem_addr = 32'h100; mem_rmask = 4'hF; mem_rdata = 32'hDEADBEEF;
        wb_valid = 1; wb_rd_addr = 5; wb_rd_wdata = 32'hDEADBEEF;
        ret_valid = 1; ret_pc_next = 32'h1008;
        step(); idle_inputs();
        check("lw_valid", rvfi_valid, 1);
        check("lw_order", rvfi_order, 1);
        check("lw_rs2_rdata_zero", rvfi_rs2_rdata, 0);
        check("lw_mem_addr", rvfi_mem_addr, 32'h100);
        check("lw_rmask", rvfi_mem_rmask, 4'hF);
        check("lw_wmask", rvfi_mem_wmask, 0);
        check("lw_mem_rdata", rvfi_mem_rdata, 32'hDEADBEEF);
        check("lw_rd_addr", rvfi_rd_addr, 5);
        check("lw_rd_wdata", rvfi_rd_wdata, 32'hDEADBEEF);
        step();

        // SB x7,0(x8) that traps
        decode(32'h1008, 32'h00740023, 5'd8, 5'd7, 32'h200, 32'hAB);
        step(); idle_inputs();
        mem_valid = 1; mem_ready = 1; mem_addr = 32'h200; mem_wstrb = 4'h1; mem_wdata = 32'hAB;
        wb_valid = 1; wb_rd_addr = 9; wb_rd_wdata = 32'h77;
        step(); idle_inputs();
        ret_valid = 1; ret_trap = 1; ret_pc_next = 32'h80;
        step(); idle_inputs();
        check("sb_valid", rvfi_valid, 1);
        check("sb_order", rvfi_order, 2);
        check("sb_trap", rvfi_trap, 1);
        check("sb_rd_addr", rvfi_rd_addr, 0);
        check("sb_rd_wdata", rvfi_rd_wdata, 0);
        check("sb_wmask", rvfi_mem_wmask, 0);
        check("sb_mem_addr", rvfi_mem_addr, 32'h200);
        check("sb_pc_wdata", rvfi_pc_wdata, 32'h80);
        check("sb_err_clean", proto_err, 0);
        step();

        // Back-to-back: next decode lands in the EMIT cycle
        decode(32'h2000, 32'h00100093, 5'd0, 5'd0, 0, 0);
        step(); idle_inputs();
        wb_valid = 1; wb_rd_addr = 1; wb_rd_wdata = 1; ret_valid = 1; ret_pc_next = 32'h2004;
        step(); idle_inputs();
        check("b2b_a_valid", rvfi_valid, 1);
        check("b2b_a_order", rvfi_order, 3);
        check("b2b_a_insn", rvfi_insn, 32'h00100093);
        decode(32'h2004, 32'h00200113, 5'd0, 5'd0, 0, 0);
        step(); idle_inputs();
        check("b2b_gap", rvfi_valid, 0);
        wb_valid = 1; wb_rd_addr = 2; wb_rd_wdata = 2; ret_valid = 1; ret_pc_next = 32'h2008;
        step(); idle_inputs();
        check("b2b_b_valid", rvfi_valid, 1);
        check("b2b_b_order", rvfi_order, 4);
        check("b2b_b_insn", rvfi_insn, 32'h00200113);
        check("b2b_b_pc", rvfi_pc_rdata, 32'h2004);
        check("b2b_b_rd_wdata", rvfi_rd_wdata, 2);
        step();

        // Decode while a packet is open, then retire with no packet open
        decode(32'h3000, 32'h00300193, 5'd0, 5'd0, 0, 0);
        step(); idle_inputs();
        decode(32'h3004, 32'h00400213, 5'd0, 5'd0, 0, 0);
        step(); idle_inputs();
        check("restart_err", proto_err, 1);
        check("restart_no_pkt", rvfi_valid, 0);
        wb_valid = 1; wb_rd_addr = 4; wb_rd_wdata = 4; ret_valid = 1; ret_pc_next = 32'h3008;
        step(); idle_inputs();
        check("restart_valid", rvfi_valid, 1);
        check("restart_insn", rvfi_insn, 32'h00400213);
        check("restart_pc", rvfi_pc_rdata, 32'h3004);
        check("restart_order", rvfi_order, 5);
        step();
        ret_valid = 1; ret_pc_next = 32'h4000;
        step(); idle_inputs();
        check("idle_ret_no_pkt", rvfi_valid, 0);
        step();
        check("idle_ret_no_pkt2", rvfi_valid, 0);
        check("idle_ret_order", rvfi_order, 6);
        check("idle_ret_pc_hold", rvfi_pc_wdata, 32'h3008);

        // Reset mid-packet, then a second data handshake in one packet
        decode(32'h5000, 32'h00500293, 5'd0, 5'd0, 0, 0);
        step(); idle_inputs();
        reset = 0;
        step();
        reset = 1;
        step();
        check("rst_mid_valid", rvfi_valid, 0);
        check("rst_mid_order", rvfi_order, 0);
        check("rst_mid_err", proto_err, 0);
        decode(32'h6000, 32'h00032303, 5'd6, 5'd0, 32'h400, 0);
        step(); idle_inputs();
        mem_valid = 1; mem_ready = 1; mem_addr = 32'h400; mem_rmask = 4'hF; mem_rdata = 32'h1;
        step(); idle_inputs();
        check("mem1_err_clean", proto_err, 0);
        mem_valid = 1; mem_ready = 1; mem_addr = 32'h500; mem_rmask = 4'hF; mem_rdata = 32'h2;
        step(); idle_inputs();
        check("mem2_err", proto_err, 1);
        ret_valid = 1; ret_pc_next = 32'h6004;
        step(); idle_inputs();
        check("mem2_valid", rvfi_valid, 1);
        check("mem2_keep_addr", rvfi_mem_addr, 32'h400);
        check("mem2_keep_rdata", rvfi_mem_rdata, 32'h1);
        check("mem2_order", rvfi_order, 0);
        step();

        // Order wrap-around
        force dut.order_reg = {64{1'b1}};
        #1;
        release dut.order_reg;
        decode(32'h7000, 32'h00000013, 5'd0, 5'd0, 0, 0);
        step(); idle_inputs();
        ret_valid = 1; ret_pc_next = 32'h7004;
        step(); idle_inputs();
        check("wrap_valid", rvfi_valid, 1);
        check("wrap_order_max", rvfi_order, {64{1'b1}});
        step();
        decode(32'h7004, 32'h00000013, 5'd0, 5'd0, 0, 0);
        step(); idle_inputs();
        ret_valid = 1; ret_pc_next = 32'h7008;
        step(); idle_inputs();
        check("wrap_next_valid", rvfi_valid, 1);
        check("wrap_order_zero", rvfi_order, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
